// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  // Frame-level states of the loader.
  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_t;

  localparam logic [7:0] BOOT_MAGIC    = 8'hA5;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Byte address of word idx, wrapping at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start glitch rejection.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state_q;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  // Synchronize the line, time the bits and shift in LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync1_q      <= rx_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a UART program image into RAM over AHB-Lite and releases the CPU once verified.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written,
  output boot_state_t dbg_state
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  boot_state_t state_q;
  logic [15:0] len_q, word_idx_q, ww_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q, buf_q, haddr_q, hwdata_q;
  logic [7:0]  csum_q;
  logic        csum_ok_q, aph_q, dph_q, hwrite_q, done_q, err_q, cpu_hold_q;
  logic [1:0]  htrans_q;

  // AHB handshake: a phase (address or data) completes only on a cycle with
  // hready=1; until then every bus output holds its value. aph_q/dph_q mark an
  // address or data phase in progress; hresp is only looked at as a data phase completes.
  logic        wr_done, bus_err, busy, live;
  logic [15:0] len_d;
  logic [31:0] word_d;
  assign wr_done = dph_q & hready;
  assign bus_err = wr_done & hresp;
  assign busy    = aph_q | (dph_q & ~hready);
  assign live    = (state_q != DONE) && (state_q != ERR);
  assign len_d   = {rx_data, len_q[7:0]};
  assign word_d  = {rx_data, word_q[31:8]};

  // Frame FSM, word assembler and single-outstanding AHB write engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      csum_ok_q  <= 1'b0;
      buf_q      <= '0;
      aph_q      <= 1'b0;
      dph_q      <= 1'b0;
      haddr_q    <= '0;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
      ww_q       <= '0;
    end else begin
      if (wr_done) begin
        dph_q <= 1'b0;
        if (!hresp) ww_q <= ww_q + 16'd1;
      end
      if (aph_q && hready) begin
        aph_q    <= 1'b0;
        dph_q    <= 1'b1;
        htrans_q <= HTRANS_IDLE;
        hwrite_q <= 1'b0;
        hwdata_q <= buf_q;
      end

      if (live && (bus_err || rx_frame_err)) begin
        state_q <= ERR;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (rx_valid && rx_data == BOOT_MAGIC) state_q <= LEN0;
          LEN0: if (rx_valid) begin
            len_q[7:0] <= rx_data;
            state_q    <= LEN1;
          end
          LEN1: if (rx_valid) begin
            len_q      <= len_d;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            csum_ok_q  <= 1'b0;
            if (len_d == 16'd0) begin
              state_q <= CSUM;
            end else if ({1'b0, len_d} > 17'(MAX_WORDS)) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: if (rx_valid) begin
            csum_q     <= csum_q ^ rx_data;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (busy) begin
                // Holding buffer still owned by the previous write: overflow.
                state_q <= ERR;
                err_q   <= 1'b1;
              end else begin
                aph_q      <= 1'b1;
                htrans_q   <= HTRANS_NONSEQ;
                hwrite_q   <= 1'b1;
                haddr_q    <= word_addr(BASE_ADDR, word_idx_q);
                buf_q      <= word_d;
                word_idx_q <= word_idx_q + 16'd1;
                if (word_idx_q + 16'd1 == len_q) state_q <= CSUM;
              end
            end
          end
          CSUM: begin
            if (!csum_ok_q) begin
              if (rx_valid) begin
                if (rx_data != csum_q) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                end else if (!busy) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
                end else begin
                  csum_ok_q <= 1'b1;
                end
              end
            end else if (!busy) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign haddr         = haddr_q;
  assign htrans        = htrans_q;
  assign hwrite        = hwrite_q;
  assign hsize         = HSIZE_WORD;
  assign hwdata        = hwdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed + randomized bench for uart_boot_loader with an AHB slave model and frame reference model.
module tb_uart_boot_loader;
  import boot_pkg::*;

  localparam int          CLKS = 16;
  localparam logic [31:0] BASE = 32'h2000_0100;
  localparam int          MAXW = 8;

  logic        clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, hready = 1'b1, hresp = 1'b0;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite, cpu_hold, done, err;
  logic [2:0]  hsize;
  logic [15:0] words_written;
  boot_state_t dbg_state;

  // Clock/reset.
  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(CLKS), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hresp(hresp),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_written(words_written),
    .dbg_state(dbg_state)
  );

  int total = 0, passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard state: expected writes {addr,data}, observed writes, frame contents.
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [31:0] words[$];
  logic [7:0]  tx_q[$];
  bit          exp_done;

  // AHB slave model: inserts stall_n wait cycles per phase, optionally errors the first data phase.
  int          stall_n = 0;
  bit          err_first = 1'b0, first_done = 1'b0, in_dph = 1'b0, stalled = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] dph_addr = '0, prev_haddr = '0, prev_hwdata = '0;
  logic [1:0]  prev_htrans = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_dph = 1'b0; wait_cnt = 0; stalled = 1'b0; first_done = 1'b0;
      hready = 1'b1; hresp = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_haddr", haddr, prev_haddr);
        check("stall_htrans", 32'(htrans), 32'(prev_htrans));
        if (in_dph) check("stall_hwdata", hwdata, prev_hwdata);
      end
      if (htrans == HTRANS_NONSEQ) check("aph_hwrite", 32'(hwrite), 32'd1);
      hresp = 1'b0;
      if (in_dph || htrans == HTRANS_NONSEQ) begin
        if (wait_cnt < stall_n) begin
          hready = 1'b0; wait_cnt++; stalled = 1'b1;
          prev_haddr = haddr; prev_hwdata = hwdata; prev_htrans = htrans;
        end else begin
          hready = 1'b1; wait_cnt = 0; stalled = 1'b0;
          if (in_dph) begin
            if (err_first && !first_done) hresp = 1'b1;
            else got_q.push_back({dph_addr, hwdata});
            first_done = 1'b1;
          end
          in_dph   = (htrans == HTRANS_NONSEQ);
          dph_addr = haddr;
        end
      end else begin
        hready = 1'b1; stalled = 1'b0;
      end
    end
  end

  // Driver tasks.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLKS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_haddr"}, haddr, 32'd0);
    check({tag, "_htrans"}, 32'(htrans), 32'd0);
    check({tag, "_hwrite"}, 32'(hwrite), 32'd0);
    check({tag, "_hsize"}, 32'(hsize), 32'd2);
    check({tag, "_hwdata"}, hwdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ww"}, 32'(words_written), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    stall_n = 0;
    err_first = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Reference model: frame bytes, expected writes and final outcome.
  task automatic build_frame(input int len_field, input logic [7:0] csum_flip);
    logic [7:0] cs;
    cs = 8'h00;
    tx_q.delete();
    exp_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(len_field[7:0]);
    tx_q.push_back(len_field[15:8]);
    exp_done = 1'b0;
    if (len_field > MAXW) return;
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        tx_q.push_back(words[i][8*b +: 8]);
        cs = cs ^ words[i][8*b +: 8];
      end
      exp_q.push_back({BASE + 32'(4 * i), words[i]});
    end
    tx_q.push_back(cs ^ csum_flip);
    exp_done = (csum_flip == 8'h00);
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (!(done || err) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 600), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(!exp_done));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_ww"}, 32'(words_written), 32'(exp_q.size()));
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_q[i][63:32], exp_q[i][63:32]);
      check($sformatf("%s_data%0d", tag, i), got_q[i][31:0], exp_q[i][31:0]);
    end
    check({tag, "_htrans_idle"}, 32'(htrans), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    do_reset("rst0");

    // Single word, good checksum (A5 01 00 78 56 34 12 08).
    words.delete(); words.push_back(32'h1234_5678);
    build_frame(1, 8'h00);
    send_frame();
    finish_frame("one");

    // Same frame with checksum 09.
    do_reset("rst1");
    build_frame(1, 8'h01);
    send_frame();
    finish_frame("badcs");

    // Two words, 3 wait states in every phase.
    do_reset("rst2");
    stall_n = 3;
    rand_words(2);
    build_frame(2, 8'h00);
    send_frame();
    finish_frame("stall");

    // Zero length: no bus activity.
    do_reset("rst3");
    words.delete();
    build_frame(0, 8'h00);
    send_frame();
    finish_frame("len0");

    // Length above the maximum: header alone triggers the error.
    do_reset("rst4");
    rand_words(MAXW + 1);
    build_frame(MAXW + 1, 8'h00);
    send_frame();
    finish_frame("toolong");

    // Bus error on the first data phase.
    do_reset("rst5");
    err_first = 1'b1;
    rand_words(2);
    build_frame(2, 8'h00);
    exp_q.delete();
    exp_q.push_back({BASE + 32'd4, words[1]});
    exp_q.delete();
    exp_done = 1'b0;
    send_frame();
    finish_frame("hresp");

    // Framing error on the byte after the magic.
    do_reset("rst6");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b0);
    exp_q.delete();
    exp_done = 1'b0;
    finish_frame("frame");

    // Junk, a short glitch, then a reset in the middle of a stalled write.
    do_reset("rst7");
    send_byte(8'h3C, 1'b1);
    send_byte(8'hFF, 1'b1);
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check("junk_err", 32'(err), 32'd0);
    check("junk_state", 32'(dbg_state), 32'(IDLE));
    stall_n = 1000;
    rand_words(2);
    build_frame(2, 8'h00);
    for (int i = 0; i < 7; i++) send_byte(tx_q[i], 1'b1);
    n = 0;
    while (htrans != HTRANS_NONSEQ && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_aph_seen", 32'(htrans), 32'(HTRANS_NONSEQ));
    check("mid_state", 32'(dbg_state), 32'(DATA));
    do_reset("midrst");
    check_reset_vals("post_rst");
    rand_words(3);
    build_frame(3, 8'h00);
    send_frame();
    finish_frame("fresh");

    // Randomized frames.
    for (int t = 0; t < 3; t++) begin
      do_reset($sformatf("rrst%0d", t));
      stall_n = $urandom_range(0, 2);
      rand_words($urandom_range(1, MAXW));
      build_frame(words.size(), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      send_frame();
      finish_frame($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
